// File: rtl/cdc_pkg.sv
// cdc_pkg: shared FSM state encodings and event record sizing for sync_edge_filter
package cdc_pkg;
  typedef enum logic [1:0] {S_LOW, S_QUAL_HIGH, S_HIGH, S_QUAL_LOW} state_t;
  localparam int TS_WIDTH_DEF = 16;
  localparam int EVT_WIDTH_DEF = 1 + TS_WIDTH_DEF;
  function automatic int evt_width(int ts_w);
    return 1 + ts_w;
  endfunction
endpackage

// File: rtl/evt_slot.sv
// evt_slot: one-entry valid/ready holding register with sticky drop detection
module evt_slot import cdc_pkg::*; #(
  parameter int W = EVT_WIDTH_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] din,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] dout,
  output logic         overflow
);
  logic take;
  // a load is accepted when the slot is empty or is being drained on this edge
  assign take = load & (~valid | ready);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      dout     <= '0;
      overflow <= 1'b0;
    end else begin
      if (take) begin
        valid <= 1'b1;
        dout  <= din;
      end else if (ready) begin
        valid <= 1'b0;
      end
      overflow <= clr ? 1'b0 : overflow | (load & valid & ~ready);
    end
  end
endmodule

// File: rtl/sync_edge_filter.sv
// sync_edge_filter: glitch filter on a synchronized level with edge pulses,
// saturating edge counter and timestamped event records
module sync_edge_filter import cdc_pkg::*; #(
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_WIDTH     = 8,
  parameter int TS_WIDTH      = TS_WIDTH_DEF
) (
  input  logic                 dst_clk,
  input  logic                 rst_n,
  input  logic                 sync_data,
  input  logic                 clr,
  output logic                 filt_data,
  output logic                 rise_pulse,
  output logic                 fall_pulse,
  output logic [CNT_WIDTH-1:0] edge_count,
  output logic                 evt_valid,
  input  logic                 evt_ready,
  output logic                 evt_rising,
  output logic [TS_WIDTH-1:0]  evt_time,
  output logic                 evt_overflow
);
  localparam int EW = evt_width(TS_WIDTH);
  localparam logic [7:0] FC = 8'(FILTER_CYCLES);
  state_t state;
  logic [7:0] qcnt;
  logic [TS_WIDTH-1:0] ts;
  logic [EW-1:0] rec;
  logic qual_done, rise_q, fall_q;
  assign qual_done = (qcnt + 8'd1) == FC;
  // qualifying edges are decoded combinationally so every consumer updates on the same edge
  assign rise_q = sync_data & ((state == S_LOW) ? (FC == 8'd1) : (state == S_QUAL_HIGH) & qual_done);
  assign fall_q = ~sync_data & ((state == S_HIGH) ? (FC == 8'd1) : (state == S_QUAL_LOW) & qual_done);
  always_ff @(posedge dst_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_LOW;
      qcnt       <= '0;
      filt_data  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= rise_q;
      fall_pulse <= fall_q;
      if (rise_q) begin
        state     <= S_HIGH;
        qcnt      <= '0;
        filt_data <= 1'b1;
      end else if (fall_q) begin
        state     <= S_LOW;
        qcnt      <= '0;
        filt_data <= 1'b0;
      end else begin
        case (state)
          S_LOW:       if (sync_data) begin state <= S_QUAL_HIGH; qcnt <= 8'd1; end
          S_QUAL_HIGH: if (sync_data) qcnt <= qcnt + 8'd1; else begin state <= S_LOW; qcnt <= '0; end
          S_HIGH:      if (!sync_data) begin state <= S_QUAL_LOW; qcnt <= 8'd1; end
          S_QUAL_LOW:  if (!sync_data) qcnt <= qcnt + 8'd1; else begin state <= S_HIGH; qcnt <= '0; end
          default:     begin state <= S_LOW; qcnt <= '0; end
        endcase
      end
    end
  end
  always_ff @(posedge dst_clk or negedge rst_n) begin
    if (!rst_n) begin
      ts         <= '0;
      edge_count <= '0;
    end else begin
      ts         <= ts + 1'b1;
      edge_count <= clr ? '0 : edge_count + CNT_WIDTH'((rise_q | fall_q) & ~&edge_count);
    end
  end
  evt_slot #(.W(EW)) u_slot (
    .clk      (dst_clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .load     (rise_q | fall_q),
    .din      ({rise_q, ts}),
    .ready    (evt_ready),
    .valid    (evt_valid),
    .dout     (rec),
    .overflow (evt_overflow)
  );
  assign {evt_rising, evt_time} = rec;
endmodule

// File: tb/tb_sync_edge_filter.sv
// tb_sync_edge_filter: randomized check of two filter configurations against a run-length reference model
module tb_sync_edge_filter;
  logic dst_clk, rst_n, sync_data, clr, evt_ready;
  logic f0, r0, fa0, v0, er0, ov0, f1, r1, fa1, v1, er1, ov1;
  logic [7:0] ec0;
  logic [1:0] ec1;
  logic [15:0] et0, et1;
  int n_tests = 0, n_fail = 0;
  int fcs[2] = '{4, 1};
  int cmax[2] = '{255, 3};
  int fl[2], run[2], m_rise[2], m_fall[2], cnt[2], mv[2], mr[2], mt[2], mo[2];
  int ts;
  int seg_left = 0, seg_lvl = 0;

  sync_edge_filter #(.FILTER_CYCLES(4), .CNT_WIDTH(8), .TS_WIDTH(16)) dut0 (
    .dst_clk(dst_clk), .rst_n(rst_n), .sync_data(sync_data), .clr(clr),
    .filt_data(f0), .rise_pulse(r0), .fall_pulse(fa0), .edge_count(ec0),
    .evt_valid(v0), .evt_ready(evt_ready), .evt_rising(er0), .evt_time(et0), .evt_overflow(ov0));
  sync_edge_filter #(.FILTER_CYCLES(1), .CNT_WIDTH(2), .TS_WIDTH(16)) dut1 (
    .dst_clk(dst_clk), .rst_n(rst_n), .sync_data(sync_data), .clr(clr),
    .filt_data(f1), .rise_pulse(r1), .fall_pulse(fa1), .edge_count(ec1),
    .evt_valid(v1), .evt_ready(evt_ready), .evt_rising(er1), .evt_time(et1), .evt_overflow(ov1));

  initial begin
    dst_clk = 0;
    forever #5 dst_clk = ~dst_clk;
  end

  task automatic chk(string tag, int got, int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      fl[i] = 0; run[i] = 0; m_rise[i] = 0; m_fall[i] = 0;
      cnt[i] = 0; mv[i] = 0; mr[i] = 0; mt[i] = 0; mo[i] = 0;
    end
    ts = 0;
  endtask

  // filtered level flips once FILTER_CYCLES consecutive samples disagree with it
  task automatic model_step();
    int d, ev;
    d = int'(sync_data);
    for (int i = 0; i < 2; i++) begin
      ev = 0; m_rise[i] = 0; m_fall[i] = 0;
      if (d != fl[i]) begin
        run[i]++;
        if (run[i] == fcs[i]) begin
          fl[i] = d; run[i] = 0; ev = 1; m_rise[i] = d; m_fall[i] = 1 - d;
        end
      end else run[i] = 0;
      if (ev && cnt[i] < cmax[i]) cnt[i]++;
      if (ev && mv[i] && !evt_ready) mo[i] = 1;
      else if (ev) begin mv[i] = 1; mr[i] = d; mt[i] = ts; end
      else if (evt_ready) mv[i] = 0;
      if (clr) begin cnt[i] = 0; mo[i] = 0; end
    end
    ts = (ts + 1) % 65536;
  endtask

  task automatic check_all();
    chk("filt0", f0, fl[0]);   chk("filt1", f1, fl[1]);
    chk("rise0", r0, m_rise[0]); chk("rise1", r1, m_rise[1]);
    chk("fall0", fa0, m_fall[0]); chk("fall1", fa1, m_fall[1]);
    chk("count0", ec0, cnt[0]); chk("count1", ec1, cnt[1]);
    chk("valid0", v0, mv[0]);  chk("valid1", v1, mv[1]);
    chk("rising0", er0, mr[0]); chk("rising1", er1, mr[1]);
    chk("time0", et0, mt[0]);  chk("time1", et1, mt[1]);
    chk("ovf0", ov0, mo[0]);   chk("ovf1", ov1, mo[1]);
  endtask

  task automatic step(logic d, logic rdy, logic c);
    sync_data = d; evt_ready = rdy; clr = c;
    @(posedge dst_clk);
    model_step();
    @(negedge dst_clk);
    check_all();
  endtask

  task automatic do_reset(logic d_rel);
    rst_n = 0;
    #1;
    model_reset();
    check_all();
    sync_data = d_rel; clr = 0; evt_ready = 0;
    @(negedge dst_clk);
    @(negedge dst_clk);
    rst_n = 1;
  endtask

  task automatic rand_cycles(int n, int max_seg, int rdy_mod, int clr_mod);
    for (int k = 0; k < n; k++) begin
      if (seg_left == 0) begin
        seg_lvl = int'($urandom_range(0, 1));
        seg_left = int'($urandom_range(1, max_seg));
      end
      seg_left--;
      step(1'(seg_lvl), $urandom_range(0, rdy_mod - 1) == 0, $urandom_range(0, clr_mod - 1) == 0);
    end
  endtask

  initial begin
    rst_n = 0; sync_data = 0; clr = 0; evt_ready = 0;
    model_reset();
    @(negedge dst_clk);
    check_all();
    @(negedge dst_clk);
    rst_n = 1;
    repeat (10) step(1, 0, 0);
    repeat (10) step(0, 0, 0);
    step(0, 1, 0);
    repeat (3) step(1, 1, 0);
    repeat (4) step(0, 1, 0);
    repeat (2) step(1, 0, 0);
    do_reset(0);
    repeat (6) step(0, 0, 0);
    do_reset(1);
    repeat (6) step(1, 0, 0);
    rand_cycles(600, 8, 2, 40);
    rand_cycles(400, 10, 8, 60);
    rand_cycles(300, 4, 3, 25);
    repeat (2) step(1, 0, 0);
    do_reset(0);
    rand_cycles(200, 7, 2, 50);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
